// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 (8E1/8O1 when UART_RX_PARITY_EN is defined).
// Ports: sys_clk, rst (sync, high); rx serial in; rx_data/rx_valid/frame_err/parity_err/busy out.
module uart_rx #(
  parameter int unsigned CLK        = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV = CLK / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          pmis_q, pmis_d;
`else
  logic          unused_par;
  assign unused_par = PARITY_ODD;
`endif

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pmis_d  = pmis_q;
`endif
    if (state_q == S_IDLE || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          state_d = S_START;
          tcnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            // line back high by mid start bit: a glitch
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            pmis_d  = rx_s_q ^ (^shift_q) ^ PARITY_ODD;
            state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            // leave at mid stop bit so a following start edge is caught
            state_d = S_IDLE;
            data_d  = shift_q;
            if (!rx_s_q) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (pmis_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              valid_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      pmis_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
`ifdef UART_RX_PARITY_EN
      pmis_q    <= pmis_d;
`endif
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 160 clk per bit.
// Expected pulses are queued as frames are sent and popped by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 10_000;
  localparam int unsigned OS     = 16;
  localparam int          BIT    = 160;
  localparam bit          PODD   = 1'b0;

  localparam logic [2:0] F_VALID = 3'b100;
  localparam logic [2:0] F_FRAME = 3'b010;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] F_PAR   = 3'b001;
`endif

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(
    .CLK(CLK_HZ),
    .BAUD_RATE(BAUD),
    .OVERSAMPLE(OS),
    .PARITY_ODD(PODD)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [2:0] flags;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_pulse = 1'b0;

  always @(negedge sys_clk) begin
    logic [2:0] f;
    exp_t e;
    f = {rx_valid, frame_err, parity_err};
    if (!rst) begin
      if (prev_pulse) begin
        n_checks++;
        if (f !== 3'b000)
          $display("FAIL pulse_width flags=%b required=000", f);
        else
          n_pass++;
      end
      if (f !== 3'b000) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_pulse flags=%b data=%h", f, rx_data);
        end else begin
          e = sb.pop_front();
          if (f !== e.flags || rx_data !== e.data)
            $display("FAIL frame flags=%b data=%h required flags=%b data=%h",
                     f, rx_data, e.flags, e.data);
          else
            n_pass++;
        end
      end
    end
    prev_pulse = (f !== 3'b000);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_flip = 1'b0);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BIT);
    end
    rx = (^d) ^ PODD ^ par_flip;
    idle(BIT);
    rx = stop_b;
    idle(BIT);
    rx = 1'b1;
  endtask
`else
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(BIT);
    end
    rx = stop_b;
    idle(BIT);
    rx = 1'b1;
  endtask
`endif

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge sys_clk);
      n++;
    end
    idle(20);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    idle(4);
    n_checks++;
    if (rx_data !== 8'h00) $display("FAIL rst_data got=%h want=00", rx_data);
    else n_pass++;
    n_checks++;
    if (rx_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", rx_valid);
    else n_pass++;
    n_checks++;
    if (frame_err !== 1'b0) $display("FAIL rst_ferr got=%b want=0", frame_err);
    else n_pass++;
    n_checks++;
    if (parity_err !== 1'b0) $display("FAIL rst_perr got=%b want=0", parity_err);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy);
    else n_pass++;
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_basic();
    sb.push_back({F_VALID, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        idle(800);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy_mid got=%b want=1", busy);
        else n_pass++;
      end
    join
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_end got=%b want=0", busy);
    else n_pass++;
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL basic_drain pending=%0d want=0", sb.size());
      sb.delete();
    end else n_pass++;
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    idle(30);
    rx = 1'b1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL glitch_busy got=%b want=1", busy);
    else n_pass++;
    idle(100);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL glitch_idle got=%b want=0", busy);
    else n_pass++;
    idle(300);
    n_checks++;
    if (rx_data !== 8'hA5) $display("FAIL glitch_data got=%h want=a5", rx_data);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    sb.push_back({F_FRAME, 8'h3C});
    send_frame(8'h3C, 1'b0);
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL ferr_drain pending=%0d want=0", sb.size());
      sb.delete();
    end else n_pass++;
    idle(200);
  endtask

  task automatic test_back_to_back();
    sb.push_back({F_VALID, 8'h00});
    sb.push_back({F_VALID, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL b2b_drain pending=%0d want=0", sb.size());
      sb.delete();
    end else n_pass++;
    idle(200);
  endtask

  task automatic test_rst_mid();
    logic [7:0] d;
    d  = 8'h5A;
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      idle(BIT);
    end
    rx = d[4];
    idle(80);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy);
    else n_pass++;
    n_checks++;
    if (rx_data !== 8'h00) $display("FAIL rstmid_data got=%h want=00", rx_data);
    else n_pass++;
    // the sender is reset along with the receiver: line returns to idle
    rx = 1'b1;
    idle(500);
    sb.push_back({F_VALID, 8'h81});
    send_frame(8'h81, 1'b1);
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL rstmid_drain pending=%0d want=0", sb.size());
      sb.delete();
    end else n_pass++;
    n_checks++;
    if (rx_data !== 8'h81) $display("FAIL rstmid_hold got=%h want=81", rx_data);
    else n_pass++;
    idle(200);
  endtask

  task automatic test_break();
    sb.push_back({F_FRAME, 8'h00});
    rx = 1'b0;
    idle(BIT * 20);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL break_busy got=%b want=0", busy);
    else n_pass++;
    rx = 1'b1;
    idle(400);
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL break_drain pending=%0d want=0", sb.size());
      sb.delete();
    end else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    sb.push_back({F_VALID, 8'h07});
    send_frame(8'h07, 1'b1, 1'b0);
    idle(200);
    sb.push_back({F_PAR, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL parity_drain pending=%0d want=0", sb.size());
      sb.delete();
    end else n_pass++;
    idle(200);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_rst_mid();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
